semaforo_ctrl: RTL and testbench
================================

# semaforo_ctrl

Sequential controller for a two-road intersection (roads A and B). It sequences each road through green, yellow and all-red phases using cycle timers. It arbitrates right-of-way between the two roads from car-presence sensors, and drives the six lamp outputs directly. It replaces purely sensor-decoded lamp selection with a timed, safe phase sequence.

## Interface
- `GREEN_MIN`, default 20: minimum green duration in cycles (≥1).
- `GREEN_MAX`, default 60: green duration, in cycles, after which a contested green is forced to end (≥`GREEN_MIN`).
- `YELLOW_T`, default 5: yellow duration in cycles (≥1).
- `ALLRED_T`, default 2: all-red clearance duration in cycles (≥1).
- `BLINK_T`, default 10: blink half-period in cycles. Used only with `SEMAFORO_NOITE_EN`.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `sa` input 1: car present on road A; level signal, synchronous to `clk`.
- `sb` input 1: car present on road B; level signal, synchronous to `clk`.
- `noite` input 1: night-mode request. The port exists only with `SEMAFORO_NOITE_EN`.
- `VMA`, `AMA`, `VDA` output 1 each: road A red / yellow / green.
- `VMB`, `AMB`, `VDB` output 1 each: road B red / yellow / green.

## Operation
- Moore FSM with states GA, YA, RRA, GB, YB, RRB (plus NOITE with the macro).
- Outputs decode from the registered state only.
  - GA: `VDA`=1, `VMB`=1.
  - YA: `AMA`=1, `VMB`=1.
  - RRA and RRB: `VMA`=1, `VMB`=1.
  - GB: `VMA`=1, `VDB`=1.
  - YB: `VMA`=1, `AMB`=1.
  - All other outputs are 0.
- Exactly one lamp per road is lit in every non-night state. A green is never adjacent to the other road's green or yellow.
- Phase counter `cnt`:
  - Width is `$clog2` of the largest timing parameter, plus 1.
  - Cleared to 0 on every state change.
  - Otherwise increments each cycle.
  - In green states it saturates at `GREEN_MAX`-1.
- Green exit, shown for GA (GB is symmetric with `sa`/`sb` swapped). Leave GA when all of the following hold:
  - `sb`=1,
  - `cnt`+1 ≥ `GREEN_MIN`,
  - and either `sa`=0 or `cnt`+1 ≥ `GREEN_MAX`.
- With no opposing request, green holds indefinitely.
- Sensors are not latched: a request that drops before the exit condition is met is lost.
- Phase sequence:
  - YA → RRA after exactly `YELLOW_T` cycles; RRA → GB after exactly `ALLRED_T` cycles.
  - GB → YB → RRB → GA uses the same rule.
- Both sensors high continuously: road A and road B alternate, each holding green for `GREEN_MAX` cycles.

## Timing
- Reset (`reset_n`=0, asynchronous, any state): state GA, `cnt`=0.
  - Outputs immediately become `VDA`=1, `VMB`=1, all others 0.
- First rising edge after reset release counts as GA cycle 0.
- Exit condition is evaluated combinationally from `cnt` and the sensors. The state changes at the next rising edge, so new lamps appear in the same cycle as the new state.
- Cycles in each state:
  - Green: max(`GREEN_MIN`, first cycle the exit condition holds), capped by `GREEN_MAX` when contested.
  - Yellow: exactly `YELLOW_T`.
  - All-red: exactly `ALLRED_T`.
- Sensor changes during yellow or all-red have no effect.

## Configuration
- `SEMAFORO_NOITE_EN` defined:
  - Adds the `noite` port and the NOITE state.
  - `noite`=1 in any state moves to NOITE at the next edge, with `cnt` cleared.
  - In NOITE, all red and green outputs are 0 and `AMA`=`AMB`=blink.
  - Blink starts at 1 and toggles every `BLINK_T` cycles.
  - `noite`=0 while in NOITE moves to RRB for `ALLRED_T` cycles, then to GA.
  - Reset clears the blink state.
- `SEMAFORO_NOITE_EN` undefined:
  - No `noite` port, no NOITE state, `BLINK_T` unused.
  - Behaviour is otherwise identical.

## Test plan
All scenarios use `GREEN_MIN`=4, `GREEN_MAX`=8, `YELLOW_T`=2, `ALLRED_T`=1, `BLINK_T`=3.
- Reset, `sa`=`sb`=0 for 100 cycles → `VDA`=1, `VMB`=1, others 0, throughout; no state change.
- `sb`=1, `sa`=0 from reset release → GA 4 cycles, YA 2 (`AMA`=1, `VMB`=1), RRA 1 (`VMA`=`VMB`=1), then GB held while `sa`=0.
- `sa`=`sb`=1 constantly → GA 8, YA 2, RRA 1, GB 8, YB 2, RRB 1; period of 22 cycles repeats.
- `sb` pulsed high only in GA cycle 1 → no transition (request before `GREEN_MIN` is not latched); GA persists.
- `reset_n` dropped during YA cycle 1 → outputs change to `VDA`=1, `VMB`=1 without waiting for a clock edge; after release, GA restarts with `cnt`=0.
- Macro on, `noite`=1 during GB → next edge NOITE: `AMA`=`AMB`=1 for 3 cycles, then 0 for 3 cycles, and so on. `noite`=0 → RRB 1 cycle, then GA.

Source files
------------

// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: two-road intersection controller.
// Timed green/yellow/all-red sequencing with sensor-driven right-of-way.
// Optional night blink mode: define SEMAFORO_NOITE_EN to add the `noite`
// port and the NOITE state (both yellows blink with half-period BLINK_T).
module semaforo_ctrl #(
    parameter int GREEN_MIN = 20,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int BLINK_T   = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sa,
    input  logic sb,
`ifdef SEMAFORO_NOITE_EN
    input  logic noite,
`endif
    output logic VMA,
    output logic AMA,
    output logic VDA,
    output logic VMB,
    output logic AMB,
    output logic VDB
);

    // Counter must hold the longest phase length; BLINK_T is included so the
    // night counter fits as well.
    localparam int MAX_GY = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int MAX_AB = (ALLRED_T > BLINK_T) ? ALLRED_T : BLINK_T;
    localparam int MAX_GM = (GREEN_MIN > MAX_GY) ? GREEN_MIN : MAX_GY;
    localparam int MAXP   = (MAX_GM > MAX_AB) ? MAX_GM : MAX_AB;
    localparam int CW     = $clog2(MAXP) + 1;

    // "cnt + 1 >= N" is evaluated as "cnt >= N - 1" to stay within CW bits.
    localparam logic [CW-1:0] GMIN_M1  = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_M1  = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_M1   = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_M1    = CW'(ALLRED_T - 1);
`ifdef SEMAFORO_NOITE_EN
    localparam logic [CW-1:0] BLINK_M1 = CW'(BLINK_T - 1);
`endif

    typedef enum logic [2:0] {
        GA    = 3'd0,
        YA    = 3'd1,
        RRA   = 3'd2,
        GB    = 3'd3,
        YB    = 3'd4,
        RRB   = 3'd5
`ifdef SEMAFORO_NOITE_EN
        ,
        NOITE = 3'd6
`endif
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic            is_green;
    logic            a_done;
    logic            b_done;
`ifdef SEMAFORO_NOITE_EN
    logic            blink;
`endif

    assign is_green = (state == GA) || (state == GB);

    // Green may end once the minimum is served and the other road waits;
    // a still-occupied own road keeps it until GREEN_MAX.
    assign a_done = sb && (cnt >= GMIN_M1) && (!sa || (cnt >= GMAX_M1));
    assign b_done = sa && (cnt >= GMIN_M1) && (!sb || (cnt >= GMAX_M1));

    // State register: reset lands directly in GA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= GA;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed ring GA->YA->RRA->GB->YB->RRB->GA.
    always_comb begin
        next_state = state;
        unique case (state)
            GA:  if (a_done)         next_state = YA;
            YA:  if (cnt >= YEL_M1)  next_state = RRA;
            RRA: if (cnt >= AR_M1)   next_state = GB;
            GB:  if (b_done)         next_state = YB;
            YB:  if (cnt >= YEL_M1)  next_state = RRB;
            RRB: if (cnt >= AR_M1)   next_state = GA;
`ifdef SEMAFORO_NOITE_EN
            NOITE: if (!noite)       next_state = RRB;
`endif
            default:                 next_state = GA;
        endcase
`ifdef SEMAFORO_NOITE_EN
        // Night request overrides every phase.
        if (noite) begin
            next_state = NOITE;
        end
`endif
    end

    // Phase counter: clears on any state change, saturates in green so an
    // uncontested green can hold forever without wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (is_green && (cnt >= GMAX_M1)) begin
            cnt <= GMAX_M1;
`ifdef SEMAFORO_NOITE_EN
        end else if ((state == NOITE) && (cnt >= BLINK_M1)) begin
            cnt <= '0;
`endif
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SEMAFORO_NOITE_EN
    // Blink phase: forced to 1 on NOITE entry, toggles every BLINK_T cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink <= 1'b0;
        end else if ((next_state == NOITE) && (state != NOITE)) begin
            blink <= 1'b1;
        end else if ((state == NOITE) && (cnt >= BLINK_M1)) begin
            blink <= ~blink;
        end
    end
`endif

    // Lamp decode from the registered state only (Moore outputs).
    always_comb begin
        VMA = 1'b0;
        AMA = 1'b0;
        VDA = 1'b0;
        VMB = 1'b0;
        AMB = 1'b0;
        VDB = 1'b0;
        unique case (state)
            GA:  begin VDA = 1'b1; VMB = 1'b1; end
            YA:  begin AMA = 1'b1; VMB = 1'b1; end
            RRA: begin VMA = 1'b1; VMB = 1'b1; end
            GB:  begin VMA = 1'b1; VDB = 1'b1; end
            YB:  begin VMA = 1'b1; AMB = 1'b1; end
            RRB: begin VMA = 1'b1; VMB = 1'b1; end
`ifdef SEMAFORO_NOITE_EN
            NOITE: begin AMA = blink; AMB = blink; end
`endif
            default: begin VDA = 1'b1; VMB = 1'b1; end
        endcase
    end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl with a phase/time reference model.
module tb_semaforo_ctrl;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YT   = 2;
    localparam int AT   = 1;
    localparam int BT   = 3;

    // Lamp patterns {VMA,AMA,VDA,VMB,AMB,VDB}
    localparam logic [5:0] P_GA = 6'b001_100;
    localparam logic [5:0] P_YA = 6'b010_100;
    localparam logic [5:0] P_RR = 6'b100_100;
    localparam logic [5:0] P_GB = 6'b100_001;
    localparam logic [5:0] P_YB = 6'b100_010;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sa = 1'b0;
    logic sb = 1'b0;
    logic noite_in = 1'b0;
    logic VMA, AMA, VDA, VMB, AMB, VDB;
    logic [5:0] lamps;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0..5 = GA,YA,RRA,GB,YB,RRB; 6 = night.
    // m_t = cycles already spent in the phase (unbounded).
    int m_ph = 0;
    int m_t  = 0;

    assign lamps = {VMA, AMA, VDA, VMB, AMB, VDB};

    semaforo_ctrl #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
        .ALLRED_T(AT), .BLINK_T(BT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sa(sa), .sb(sb),
`ifdef SEMAFORO_NOITE_EN
        .noite(noite_in),
`endif
        .VMA(VMA), .AMA(AMA), .VDA(VDA), .VMB(VMB), .AMB(AMB), .VDB(VDB)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_lamps(input int ph, input int t);
        logic b;
        b = ((t / BT) % 2) == 0;
        case (ph)
            0: return P_GA;
            1: return P_YA;
            2: return P_RR;
            3: return P_GB;
            4: return P_YB;
            5: return P_RR;
            default: return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
        endcase
    endfunction

    task automatic model_step(input bit a, input bit b, input bit n);
        bit adv;
        adv = 1'b0;
        if (n) begin
            if (m_ph == 6) m_t = m_t + 1;
            else begin m_ph = 6; m_t = 0; end
        end else begin
            case (m_ph)
                0: adv = b && (m_t + 1 >= GMIN) && (!a || m_t + 1 >= GMAX);
                3: adv = a && (m_t + 1 >= GMIN) && (!b || m_t + 1 >= GMAX);
                1, 4: adv = (m_t + 1 == YT);
                2, 5: adv = (m_t + 1 == AT);
                default: adv = 1'b0;
            endcase
            if (m_ph == 6) begin
                m_ph = 5; m_t = 0;
            end else if (adv) begin
                m_ph = (m_ph + 1) % 6; m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance across the edge, settle after it.
    task automatic tick(input bit a, input bit b, input bit n);
        sa = a; sb = b; noite_in = n;
        @(posedge clk);
        model_step(a, b, n);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; sa = 1'b0; sb = 1'b0; noite_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_ph = 0; m_t = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (lamps !== P_GA) begin
            errors++;
            $display("FAIL reset_async lamps=%b expected=%b", lamps, P_GA);
        end
        @(posedge clk); #1;
        checks++;
        if (lamps !== P_GA) begin
            errors++;
            $display("FAIL reset_hold lamps=%b expected=%b", lamps, P_GA);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 0);
            checks++;
            if (lamps !== P_GA) begin
                errors++;
                $display("FAIL idle cyc=%0d lamps=%b expected=%b", i, lamps, P_GA);
            end
        end
    endtask

    task automatic test_sb_only();
        logic [5:0] seq [0:29];
        // GA 4, YA 2, RRA 1, then GB held
        for (int i = 0; i < 30; i++)
            seq[i] = (i < 3) ? P_GA : (i < 5) ? P_YA : (i < 6) ? P_RR : P_GB;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(0, 1, 0);
            checks++;
            if (lamps !== seq[i] || lamps !== exp_lamps(m_ph, m_t)) begin
                errors++;
                $display("FAIL sb_only cyc=%0d lamps=%b expected=%b", i, lamps, seq[i]);
            end
        end
    endtask

    task automatic test_both();
        logic [5:0] first [0:21];
        do_reset();
        for (int i = 0; i < 66; i++) begin
            tick(1, 1, 0);
            checks++;
            if (lamps !== exp_lamps(m_ph, m_t)) begin
                errors++;
                $display("FAIL both cyc=%0d lamps=%b expected=%b", i, lamps,
                         exp_lamps(m_ph, m_t));
            end
            if (i < 22) first[i] = lamps;
            else begin
                checks++;
                if (lamps !== first[i % 22]) begin
                    errors++;
                    $display("FAIL period22 cyc=%0d lamps=%b expected=%b", i, lamps,
                             first[i % 22]);
                end
            end
        end
    endtask

    task automatic test_pulse();
        do_reset();
        tick(0, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            checks++;
            if (lamps !== P_GA) begin
                errors++;
                $display("FAIL pulse_lost cyc=%0d lamps=%b expected=%b", i, lamps, P_GA);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) tick(0, 1, 0);
        checks++;
        if (lamps !== P_YA) begin
            errors++;
            $display("FAIL pre_reset_ya lamps=%b expected=%b", lamps, P_YA);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (lamps !== P_GA) begin
            errors++;
            $display("FAIL mid_reset_async lamps=%b expected=%b", lamps, P_GA);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_ph = 0; m_t = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 0);
            checks++;
            if (lamps !== exp_lamps(m_ph, m_t)) begin
                errors++;
                $display("FAIL restart cyc=%0d lamps=%b expected=%b", i, lamps,
                         exp_lamps(m_ph, m_t));
            end
        end
    endtask

    task automatic test_random();
        bit a, b;
        do_reset();
        a = 1'b0; b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            // sticky sensors so contested and uncontested greens both occur
            if ($urandom_range(0, 9) == 0) a = ~a;
            if ($urandom_range(0, 7) == 0) b = ~b;
            tick(a, b, 0);
            checks++;
            if (lamps !== exp_lamps(m_ph, m_t)) begin
                errors++;
                $display("FAIL random cyc=%0d lamps=%b expected=%b ph=%0d t=%0d",
                         i, lamps, exp_lamps(m_ph, m_t), m_ph, m_t);
            end
        end
    endtask

`ifdef SEMAFORO_NOITE_EN
    task automatic test_noite();
        logic [5:0] blink_on;
        blink_on = 6'b010_010;
        do_reset();
        repeat (13) tick(1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, 1), $urandom_range(0, 1), 1);
            checks++;
            if (lamps !== (((i / 3) % 2 == 0) ? blink_on : 6'b0) ||
                lamps !== exp_lamps(m_ph, m_t)) begin
                errors++;
                $display("FAIL noite_blink cyc=%0d lamps=%b expected=%b", i, lamps,
                         exp_lamps(m_ph, m_t));
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0);
            checks++;
            if (lamps !== ((i == 0) ? P_RR : P_GA)) begin
                errors++;
                $display("FAIL noite_exit cyc=%0d lamps=%b expected=%b", i, lamps,
                         (i == 0) ? P_RR : P_GA);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_sb_only();
        test_both();
        test_pulse();
        test_reset_mid();
        test_random();
`ifdef SEMAFORO_NOITE_EN
        test_noite();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
